// File: rtl/gf180_ram_64x8_arbiter_pkg.sv
// Shared widths, FSM states and small helpers for the 64x8 SRAM arbiter.
package gf180_ram_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 64;

  // The macro's bit write enables are active-low.
  localparam logic [RAM_DATA_W-1:0] WEN_NONE = '1;
  localparam logic [RAM_DATA_W-1:0] WEN_ALL  = '0;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } ram_st_e;

  // Highest word address; the clear sweep leaves CLEAR after writing it.
  function automatic logic [RAM_ADDR_W-1:0] last_addr();
    return RAM_ADDR_W'(RAM_DEPTH - 1);
  endfunction

  // Active-high per-bit mask to the macro's active-low bit write enables.
  function automatic logic [RAM_DATA_W-1:0] mask_to_wen(input logic [RAM_DATA_W-1:0] wmask);
    return ~wmask;
  endfunction

endpackage

// File: rtl/gf180_ram_64x8_arbiter_if.sv
// One requester's req/gnt access port into the SRAM arbiter.
interface gf180_ram_64x8_arbiter_if;
  import gf180_ram_pkg::*;

  logic                  req;
  logic                  we;
  logic [RAM_ADDR_W-1:0] addr;
  logic [RAM_DATA_W-1:0] wmask;
  logic [RAM_DATA_W-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [RAM_DATA_W-1:0] rdata;

  // Requester side: drives the request fields and holds them until gnt.
  modport master (
    output req,
    output we,
    output addr,
    output wmask,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  // Arbiter side: takes the request and answers with gnt and read data.
  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wmask,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/gf180_ram_64x8_arbiter_rr_arb2.sv
// Two-way round-robin picker. Under contention the requester named by
// rr_ptr wins and the pointer moves to the loser; a lone requester is
// granted without disturbing the pointer.
module ram_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant decision and next pointer, purely from requests, enable and pointer.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      if (req0 && req1) begin
        if (rr_ptr_q) begin
          gnt1     = 1'b1;
          rr_ptr_d = 1'b0;
        end else begin
          gnt0     = 1'b1;
          rr_ptr_d = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer register; requester 0 has priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/gf180_ram_64x8_arbiter.sv
// Round-robin arbiter and sequencer for one 64x8 gf180 SRAM macro. Owns all
// macro control pins, runs clear sweeps and returns read data one cycle
// after a read grant.
module gf180_ram_64x8_arbiter
  import gf180_ram_pkg::*;
#(
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [RAM_DATA_W-1:0] CLEAR_VALUE    = 8'h00
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  gf180_ram_64x8_arbiter_if.slave  port0,
  gf180_ram_64x8_arbiter_if.slave  port1,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     ram_cen,
  output logic                     ram_gwen,
  output logic [RAM_DATA_W-1:0]    ram_wen,
  output logic [RAM_ADDR_W-1:0]    ram_a,
  output logic [RAM_DATA_W-1:0]    ram_d,
  input  logic [RAM_DATA_W-1:0]    ram_q
);

  localparam ram_st_e RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  ram_st_e               state_q;
  ram_st_e               state_d;
  logic [RAM_ADDR_W-1:0] clr_addr_q;
  logic [RAM_ADDR_W-1:0] clr_addr_d;
  logic                  rvalid0_q;
  logic                  rvalid0_d;
  logic                  rvalid1_q;
  logic                  rvalid1_d;
  logic                  arb_en;
  logic                  gnt0;
  logic                  gnt1;

  // Fields of whichever requester holds the grant this cycle.
  logic                  sel_we;
  logic [RAM_ADDR_W-1:0] sel_addr;
  logic [RAM_DATA_W-1:0] sel_wmask;
  logic [RAM_DATA_W-1:0] sel_wdata;

  ram_rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (arb_en),
    .req0  (port0.req),
    .req1  (port1.req),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // Sweep/run sequencing; a clr_start cycle in RUN is spent entering CLEAR.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    arb_en     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == last_addr()) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end
      end
      ST_RUN: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
        end else begin
          arb_en = 1'b1;
        end
      end
      default: begin
        state_d    = RESET_ST;
        clr_addr_d = '0;
      end
    endcase
  end

  // Steer the granted requester's fields toward the macro pin mux.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wmask = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = port0.we;
      sel_addr  = port0.addr;
      sel_wmask = port0.wmask;
      sel_wdata = port0.wdata;
    end else if (gnt1) begin
      sel_we    = port1.we;
      sel_addr  = port1.addr;
      sel_wmask = port1.wmask;
      sel_wdata = port1.wdata;
    end
  end

  // Macro pins: sweep write, granted access, or parked idle values.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = WEN_NONE;
    ram_a    = '0;
    ram_d    = '0;
    if (state_q == ST_CLEAR) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = WEN_ALL;
      ram_a    = clr_addr_q;
      ram_d    = CLEAR_VALUE;
    end else if (gnt0 || gnt1) begin
      ram_cen = 1'b0;
      ram_a   = sel_addr;
      if (sel_we) begin
        ram_gwen = 1'b0;
        ram_wen  = mask_to_wen(sel_wmask);
        ram_d    = sel_wdata;
      end
    end
  end

  // A read grant now means the macro output is valid for that requester next cycle.
  always_comb begin
    rvalid0_d = gnt0 && !port0.we;
    rvalid1_d = gnt1 && !port1.we;
  end

  // State, sweep counter and read-valid registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= RESET_ST;
      clr_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign busy         = (state_q == ST_CLEAR);
  assign port0.gnt    = gnt0;
  assign port1.gnt    = gnt1;
  assign port0.rvalid = rvalid0_q;
  assign port1.rvalid = rvalid1_q;
  assign port0.rdata  = ram_q;
  assign port1.rdata  = ram_q;

endmodule

// File: tb/tb_gf180_ram_64x8_arbiter.sv
// Self-checking bench for gf180_ram_64x8_arbiter: directed scenarios, then
// randomized traffic against a spec-level model of grants, pins and memory.
module tb_gf180_ram_64x8_arbiter;

  localparam logic [7:0] CLEAR_VAL = 8'h00;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       clr_start = 1'b0;
  logic       busy;
  logic       ram_cen;
  logic       ram_gwen;
  logic [7:0] ram_wen;
  logic [5:0] ram_a;
  logic [7:0] ram_d;
  logic [7:0] ram_q;

  gf180_ram_64x8_arbiter_if if0 ();
  gf180_ram_64x8_arbiter_if if1 ();

  gf180_ram_64x8_arbiter #(
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (CLEAR_VAL)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .port0     (if0),
    .port1     (if1),
    .clr_start (clr_start),
    .busy      (busy),
    .ram_cen   (ram_cen),
    .ram_gwen  (ram_gwen),
    .ram_wen   (ram_wen),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  always #5 CLK = ~CLK;

  // Behavioural stand-in for the SRAM macro, with random power-up contents.
  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 8'($urandom);
  end
  always @(posedge CLK) begin
    if (!ram_cen) begin
      if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= mem[ram_a];
    end
  end

  int check_count = 0;
  int error_count = 0;

  // Reference model state.
  logic [7:0] ref_mem [64];
  int         clr_left;
  bit         rr;
  bit         exp_rv0, exp_rv1;
  logic [7:0] exp_rd0, exp_rd1;
  bit         mg0, mg1;

  // Last sampled DUT values, for directed checks against fixed constants.
  logic       obs_gnt0, obs_gnt1, obs_rv0, obs_rv1, obs_busy;
  logic [7:0] obs_rd0, obs_rd1, obs_wen;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq0(input bit r, input bit w, input logic [5:0] a, input logic [7:0] m, input logic [7:0] d);
    if0.req = r; if0.we = w; if0.addr = a; if0.wmask = m; if0.wdata = d;
  endtask

  task automatic setReq1(input bit r, input bit w, input logic [5:0] a, input logic [7:0] m, input logic [7:0] d);
    if1.req = r; if1.we = w; if1.addr = a; if1.wmask = m; if1.wdata = d;
  endtask

  // One clock with the currently driven inputs: predict, compare at negedge, advance model.
  task automatic applyStimulus();
    bit         g0, g1;
    logic       e_cen, e_gwen, s_we;
    logic [7:0] e_wen, e_d, s_m, s_d;
    logic [5:0] e_a, s_a;
    @(negedge CLK);
    g0 = 1'b0;
    g1 = 1'b0;
    if (clr_left == 0 && !clr_start) begin
      if (if0.req && if1.req) begin
        g0 = (rr == 1'b0);
        g1 = (rr == 1'b1);
      end else begin
        g0 = if0.req;
        g1 = if1.req;
      end
    end
    s_we = g0 ? if0.we    : if1.we;
    s_a  = g0 ? if0.addr  : if1.addr;
    s_m  = g0 ? if0.wmask : if1.wmask;
    s_d  = g0 ? if0.wdata : if1.wdata;
    e_cen = 1'b1; e_gwen = 1'b1; e_wen = 8'hFF; e_a = 6'h00; e_d = 8'h00;
    if (clr_left > 0) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = 8'h00; e_a = 6'(64 - clr_left); e_d = CLEAR_VAL;
    end else if (g0 || g1) begin
      e_cen = 1'b0; e_a = s_a;
      if (s_we) begin
        e_gwen = 1'b0; e_wen = ~s_m; e_d = s_d;
      end
    end
    obs_gnt0 = if0.gnt; obs_gnt1 = if1.gnt; obs_rv0 = if0.rvalid; obs_rv1 = if1.rvalid;
    obs_rd0 = if0.rdata; obs_rd1 = if1.rdata; obs_busy = busy; obs_wen = ram_wen;
    checkOutput("busy", busy, clr_left > 0);
    checkOutput("gnt0", if0.gnt, g0);
    checkOutput("gnt1", if1.gnt, g1);
    checkOutput("rvalid0", if0.rvalid, exp_rv0);
    checkOutput("rvalid1", if1.rvalid, exp_rv1);
    if (exp_rv0) checkOutput("rdata0", if0.rdata, exp_rd0);
    if (exp_rv1) checkOutput("rdata1", if1.rdata, exp_rd1);
    checkOutput("ram_cen", ram_cen, e_cen);
    checkOutput("ram_gwen", ram_gwen, e_gwen);
    checkOutput("ram_wen", ram_wen, e_wen);
    checkOutput("ram_a", ram_a, e_a);
    checkOutput("ram_d", ram_d, e_d);
    @(posedge CLK);
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (clr_left > 0) begin
      ref_mem[64 - clr_left] = CLEAR_VAL;
      clr_left--;
    end else if (clr_start) begin
      clr_left = 64;
    end else if (g0 || g1) begin
      if (if0.req && if1.req) rr = g0 ? 1'b1 : 1'b0;
      if (s_we) begin
        ref_mem[s_a] = (ref_mem[s_a] & ~s_m) | (s_d & s_m);
      end else if (g0) begin
        exp_rv0 = 1'b1; exp_rd0 = ref_mem[s_a];
      end else begin
        exp_rv1 = 1'b1; exp_rd1 = ref_mem[s_a];
      end
    end
    mg0 = g0;
    mg1 = g1;
    #1;
  endtask

  // Asynchronous reset: outputs must take reset values without waiting for a clock.
  task automatic applyReset(input string tag);
    RST_N = 1'b0;
    #1;
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_gnt0"}, if0.gnt, 0);
    checkOutput({tag, "_gnt1"}, if1.gnt, 0);
    checkOutput({tag, "_rvalid0"}, if0.rvalid, 0);
    checkOutput({tag, "_rvalid1"}, if1.rvalid, 0);
    checkOutput({tag, "_ram_a"}, ram_a, 0);
    clr_left = 64; rr = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; mg0 = 1'b0; mg1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    setReq0(0, 0, 0, 0, 0);
    setReq1(0, 0, 0, 0, 0);
    clr_start = 1'b0;
    #3;
    applyReset("reset");

    // Power-up sweep: exactly 64 busy cycles writing 0..63.
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus();
      if (obs_busy) cnt++;
      else break;
    end
    checkOutput("t1_busy_cycles", cnt, 64);
    setReq0(1, 0, 6'h3F, 0, 0); applyStimulus();
    setReq0(0, 0, 0, 0, 0);     applyStimulus();
    checkOutput("t1_rvalid0", obs_rv0, 1);
    checkOutput("t1_rdata0", obs_rd0, 8'h00);

    // Write then read on back-to-back cycles.
    setReq0(1, 1, 6'h05, 8'hFF, 8'hA5); applyStimulus();
    checkOutput("t2_gnt_wr", obs_gnt0, 1);
    setReq0(1, 0, 6'h05, 8'h00, 8'h00); applyStimulus();
    checkOutput("t2_gnt_rd", obs_gnt0, 1);
    setReq0(0, 0, 0, 0, 0); applyStimulus();
    checkOutput("t2_rvalid0", obs_rv0, 1);
    checkOutput("t2_rdata0", obs_rd0, 8'hA5);

    // Partial-mask write.
    setReq0(1, 1, 6'h05, 8'hF0, 8'h0F); applyStimulus();
    checkOutput("t3_ram_wen", obs_wen, 8'h0F);
    setReq0(1, 0, 6'h05, 8'h00, 8'h00); applyStimulus();
    setReq0(0, 0, 0, 0, 0); applyStimulus();
    checkOutput("t3_rdata0", obs_rd0, 8'h05);

    // Contention: grants alternate starting with requester 0.
    setReq0(1, 1, 6'h01, 8'hFF, 8'h11); applyStimulus();
    setReq0(1, 1, 6'h02, 8'hFF, 8'h22); applyStimulus();
    setReq0(1, 0, 6'h01, 8'h00, 8'h00);
    setReq1(1, 0, 6'h02, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        setReq0(0, 0, 0, 0, 0);
        setReq1(0, 0, 0, 0, 0);
      end
      applyStimulus();
      if (k < 4) begin
        checkOutput("t4_gnt0", obs_gnt0, (k % 2) == 0);
        checkOutput("t4_gnt1", obs_gnt1, (k % 2) == 1);
      end
      if (k > 0) begin
        if ((k % 2) == 1) checkOutput("t4_rdata0", obs_rd0, 8'h11);
        else              checkOutput("t4_rdata1", obs_rd1, 8'h22);
      end
    end

    // Clear on command with requester 1 pending.
    setReq1(1, 1, 6'h30, 8'hFF, 8'h5A); applyStimulus();
    setReq1(1, 0, 6'h30, 8'h00, 8'h00);
    clr_start = 1'b1;
    applyStimulus();
    clr_start = 1'b0;
    cnt = 1;
    while (!obs_gnt1 && cnt < 100) begin
      applyStimulus();
      if (!obs_gnt1) cnt++;
    end
    checkOutput("t5_wait_cycles", cnt, 65);
    setReq1(0, 0, 0, 0, 0); applyStimulus();
    checkOutput("t5_rvalid1", obs_rv1, 1);
    checkOutput("t5_rdata1", obs_rd1, CLEAR_VAL);

    // Reset in the middle of a sweep, then let the restarted sweep finish.
    clr_start = 1'b1; applyStimulus(); clr_start = 1'b0;
    while (clr_left > 44) applyStimulus();
    applyReset("t6_reset");
    for (int i = 0; i < 64; i++) applyStimulus();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if (!if0.req || mg0) begin
        if ($urandom_range(0, 1) == 1)
          setReq0(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 8'($urandom));
        else
          setReq0(0, 0, 0, 0, 0);
      end
      if (!if1.req || mg1) begin
        if ($urandom_range(0, 1) == 1)
          setReq1(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 8'($urandom));
        else
          setReq1(0, 0, 0, 0, 0);
      end
      clr_start = (clr_left == 0) && ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    clr_start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
